// File: rtl/lpc_frame_sequencer.sv
// Frame-level controller for LPC synthesis: shadow-buffers 13-word frames, swaps them in at frame boundaries
// and produces the excitation stream for synthfilt. Optional macro MUTE_ON_UNDERRUN_EN zeroes x_out in underrun frames.
module lpc_frame_sequencer #(
    parameter int FRAME_LEN = 240,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sample_tick,
    input  logic [15:0]        word_in,
    input  logic               word_valid,
    output logic               word_ready,
    input  logic signed [15:0] noise_in,
    output logic signed [15:0] A0,
    output logic signed [15:0] A1,
    output logic signed [15:0] A2,
    output logic signed [15:0] A3,
    output logic signed [15:0] A4,
    output logic signed [15:0] A5,
    output logic signed [15:0] A6,
    output logic signed [15:0] A7,
    output logic signed [15:0] A8,
    output logic signed [15:0] A9,
    output logic signed [15:0] A10,
    output logic signed [15:0] x_out,
    output logic               v_out,
    output logic               frame_start,
    output logic               underrun,
    output logic               busy
);

    // state | meaning
    // IDLE  | no active frame; waits for en and a complete shadow frame
    // RUN   | emitting samples; frame boundary handled the cycle after the last v_out

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state;
    logic [15:0]         shadow [13];
    logic [3:0]          word_cnt;
    logic                shadow_full;
    logic                live;
    logic                frame_end;
    logic                act_voiced;
    logic [14:0]         act_pitch;
    logic [14:0]         act_gain;
    logic [14:0]         pitch_cnt;
    logic [CNT_W-1:0]    sample_cnt;
    logic signed [15:0]  coef [11];
    logic                mute;

    logic                pitch_mode;
    logic                do_load;
    logic signed [31:0]  noise_ext;
    logic signed [31:0]  gain_ext;
    logic signed [31:0]  noise_prod;
    logic signed [15:0]  excitation;
    logic                unused_bits;

    assign A0  = coef[0];
    assign A1  = coef[1];
    assign A2  = coef[2];
    assign A3  = coef[3];
    assign A4  = coef[4];
    assign A5  = coef[5];
    assign A6  = coef[6];
    assign A7  = coef[7];
    assign A8  = coef[8];
    assign A9  = coef[9];
    assign A10 = coef[10];

    // live keeps word_ready low while reset is held
    assign word_ready = live && !shadow_full;

    assign pitch_mode = act_voiced && (act_pitch != 15'd0);
    assign do_load    = en && shadow_full && ((state == IDLE) || frame_end);

    // gain is unsigned Q0.15, so the product always fits after the 15-bit shift
    assign noise_ext  = {{16{noise_in[15]}}, noise_in};
    assign gain_ext   = {17'd0, act_gain};
    assign noise_prod = noise_ext * gain_ext;

    assign unused_bits = ^{noise_prod[31], noise_prod[14:0], shadow[1][15]};

    always_comb begin
        excitation = noise_prod[30:15];
        if (pitch_mode) begin
            excitation = (pitch_cnt == 15'd0) ? $signed({1'b0, act_gain}) : 16'sd0;
        end
`ifdef MUTE_ON_UNDERRUN_EN
        if (mute) begin
            excitation = 16'sd0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            live        <= 1'b0;
            word_cnt    <= '0;
            shadow_full <= 1'b0;
            frame_end   <= 1'b0;
            act_voiced  <= 1'b0;
            act_pitch   <= '0;
            act_gain    <= '0;
            pitch_cnt   <= '0;
            sample_cnt  <= '0;
            x_out       <= '0;
            v_out       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            mute        <= 1'b0;
            for (int i = 0; i < 13; i++) shadow[i] <= '0;
            for (int i = 0; i < 11; i++) coef[i] <= '0;
        end else begin
            live        <= 1'b1;
            frame_start <= 1'b0;
            v_out       <= 1'b0;

            if (word_valid && word_ready) begin
                shadow[word_cnt] <= word_in;
                if (word_cnt == 4'd12) begin
                    word_cnt    <= '0;
                    shadow_full <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + 4'd1;
                end
            end

            if (do_load) begin
                for (int i = 0; i < 11; i++) coef[i] <= shadow[i + 2];
                act_voiced  <= shadow[0][15];
                act_pitch   <= shadow[0][14:0];
                act_gain    <= shadow[1][14:0];
                shadow_full <= 1'b0;
                frame_start <= 1'b1;
                sample_cnt  <= '0;
                frame_end   <= 1'b0;
                mute        <= 1'b0;
                state       <= RUN;
                busy        <= 1'b1;
                // pitch phase carries across RUN-to-RUN frame changes
                if (state == IDLE) pitch_cnt <= '0;
            end else if (state == RUN) begin
                if (frame_end) begin
                    frame_end <= 1'b0;
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        underrun    <= 1'b1;
                        sample_cnt  <= '0;
                        frame_start <= 1'b1;
                        mute        <= 1'b1;
                    end
                end else if (sample_tick) begin
                    v_out <= 1'b1;
                    x_out <= excitation;
                    if (pitch_mode) begin
                        pitch_cnt <= (pitch_cnt >= act_pitch - 15'd1) ? 15'd0 : pitch_cnt + 15'd1;
                    end
                    if (sample_cnt == LAST_SAMPLE) begin
                        frame_end  <= 1'b1;
                        sample_cnt <= '0;
                    end else begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lpc_frame_sequencer.sv
// Directed/randomized bench for lpc_frame_sequencer against a sample-level reference model.
// Honours MUTE_ON_UNDERRUN_EN the same way the design does.
module tb_lpc_frame_sequencer;

    localparam int FRAME_LEN = 240;

    logic clk = 1'b0;
    logic rst, en, sample_tick, word_valid;
    logic [15:0] word_in;
    logic signed [15:0] noise_in;
    logic word_ready, v_out, frame_start, underrun, busy;
    logic signed [15:0] A0, A1, A2, A3, A4, A5, A6, A7, A8, A9, A10, x_out;
    logic [15:0] a_arr [11];

    always #5 clk = ~clk;

    lpc_frame_sequencer #(.FRAME_LEN(FRAME_LEN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_tick(sample_tick),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
        .noise_in(noise_in),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5),
        .A6(A6), .A7(A7), .A8(A8), .A9(A9), .A10(A10),
        .x_out(x_out), .v_out(v_out), .frame_start(frame_start),
        .underrun(underrun), .busy(busy)
    );

    assign a_arr[0] = A0;  assign a_arr[1] = A1;  assign a_arr[2]  = A2;
    assign a_arr[3] = A3;  assign a_arr[4] = A4;  assign a_arr[5]  = A5;
    assign a_arr[6] = A6;  assign a_arr[7] = A7;  assign a_arr[8]  = A8;
    assign a_arr[9] = A9;  assign a_arr[10] = A10;

    int n_pass = 0;
    int n_tot  = 0;

    // reference model state
    logic [15:0] m_sh [13];
    logic [15:0] m_coef [11];
    int  m_wc, m_pitch, m_gain, m_phase;
    bit  m_full, m_voiced, m_mute, m_und;
    logic [15:0] wq [$];
    logic [15:0] nq [$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_wc = 0; m_full = 0; m_voiced = 0; m_mute = 0; m_und = 0;
        m_pitch = 0; m_gain = 0; m_phase = 0;
        for (int i = 0; i < 11; i++) m_coef[i] = 16'd0;
    endtask

    task automatic model_load();
        for (int i = 0; i < 11; i++) m_coef[i] = m_sh[i + 2];
        m_voiced = m_sh[0][15];
        m_pitch  = int'(m_sh[0][14:0]);
        m_gain   = int'(m_sh[1][14:0]);
        m_full   = 0;
        m_mute   = 0;
    endtask

    task automatic model_sample(input logic [15:0] nz, output logic [15:0] e);
        longint p;
        if (m_voiced && m_pitch != 0) begin
            e = (m_phase == 0) ? 16'(m_gain) : 16'd0;
            if (m_phase + 1 >= m_pitch) m_phase = 0;
            else m_phase++;
        end else begin
            p = longint'($signed(nz)) * longint'(m_gain);
            p = p >>> 15;
            e = p[15:0];
        end
        if (m_mute) e = 16'd0;
    endtask

    // one clock; presents the head of the word queue and tracks what the shadow buffer takes
    task automatic step();
        bit feed, take;
        feed = (wq.size() > 0);
        take = feed && !m_full;
        if (feed) begin
            word_in    = wq[0];
            word_valid = 1'b1;
            chk("word_ready", 16'(word_ready), 16'(!m_full));
        end else begin
            word_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (take) begin
            m_sh[m_wc] = wq.pop_front();
            m_wc++;
            if (m_wc == 13) begin
                m_wc = 0;
                m_full = 1;
            end
        end
        word_valid = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] w0, w1, a0, a1, a10);
        wq.push_back(w0); wq.push_back(w1); wq.push_back(a0); wq.push_back(a1);
        for (int i = 0; i < 8; i++) wq.push_back(16'($urandom));
        wq.push_back(a10);
    endtask

    task automatic check_coefs();
        for (int i = 0; i < 11; i++) chk($sformatf("A%0d", i), a_arr[i], m_coef[i]);
    endtask

    task automatic drain();
        int k = 0;
        while (wq.size() > 0 && k < 100) begin
            step();
            k++;
        end
        chk("drain_timeout", 16'(wq.size()), 16'd0);
    endtask

    task automatic run_frame(input int push_at, input bit en_last);
        logic [15:0] nz, ex;
        bit do_ld, do_und, fs_exp;
        for (int s = 0; s < FRAME_LEN; s++) begin
            if (s == push_at) begin
                push_frame(16'h0000, 16'h7FFF, 16'h0101, 16'h0202, 16'h0A0A);
                push_frame(16'h8007, 16'h1234, 16'h0303, 16'h0404, 16'h0B0B);
            end
            if (push_at >= 0 && s == push_at + 12) chk("ready_after_13", 16'(word_ready), 16'd0);
            if (s == FRAME_LEN - 1) en = en_last;
            nz = (nq.size() > 0) ? nq.pop_front() : 16'($urandom);
            noise_in    = nz;
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
            model_sample(nz, ex);
            chk("v_out_tick", 16'(v_out), 16'd1);
            chk($sformatf("x_out_s%0d", s), x_out, ex);
            if (s == FRAME_LEN - 1) begin
                chk("fs_with_vout", 16'(frame_start), 16'd0);
                do_ld  = en && m_full;
                do_und = en && !m_full;
                fs_exp = en;
                step();
                if (do_ld) model_load();
                if (do_und) begin
                    m_und = 1;
`ifdef MUTE_ON_UNDERRUN_EN
                    m_mute = 1;
`endif
                end
                chk("v_out_end", 16'(v_out), 16'd0);
                chk("frame_start_end", 16'(frame_start), 16'(fs_exp));
                chk("underrun", 16'(underrun), 16'(m_und));
                chk("busy_end", 16'(busy), 16'(en));
                check_coefs();
                step();
                chk("frame_start_once", 16'(frame_start), 16'd0);
                step();
            end else begin
                step();
                chk("v_out_gap", 16'(v_out), 16'd0);
                step();
                step();
            end
        end
    endtask

    initial begin
        int k;
        rst = 1'b0; en = 1'b0; sample_tick = 1'b0;
        word_valid = 1'b1; word_in = 16'hBEEF; noise_in = 16'sd0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_word_ready", 16'(word_ready), 16'd0);
        chk("rst_v_out", 16'(v_out), 16'd0);
        chk("rst_x_out", x_out, 16'd0);
        chk("rst_frame_start", 16'(frame_start), 16'd0);
        chk("rst_underrun", 16'(underrun), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        check_coefs();

        word_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("rel_word_ready", 16'(word_ready), 16'd1);

        repeat (3) begin
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
            chk("idle_v_out", 16'(v_out), 16'd0);
            chk("idle_busy", 16'(busy), 16'd0);
            step();
            step();
        end

        // voiced frame, pitch 4, gain 0.5
        en = 1'b1;
        push_frame(16'h8004, 16'h4000, 16'h2000, 16'hCB4B, 16'hFF11);
        drain();
        chk("full_fs", 16'(frame_start), 16'd0);
        chk("full_ready", 16'(word_ready), 16'd0);
        step();
        model_load();
        m_phase = 0;
        chk("load_fs", 16'(frame_start), 16'd1);
        chk("load_busy", 16'(busy), 16'd1);
        check_coefs();
        step();

        run_frame(100, 1'b1);                // F1 voiced; F2 and F3 queued mid-frame
        nq.push_back(16'h8000);
        nq.push_back(16'h4000);
        run_frame(-1, 1'b1);                 // F2 unvoiced, full-scale gain
        run_frame(-1, 1'b1);                 // F3 voiced pitch 7; nothing queued -> underrun
        run_frame(-1, 1'b0);                 // underrun frame, then back to IDLE

        repeat (2) begin
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
            chk("idle2_v_out", 16'(v_out), 16'd0);
            step();
            step();
        end

        // reset after 7 of 13 words
        push_frame(16'h8005, 16'h1000, 16'h1111, 16'h2222, 16'h3333);
        k = 0;
        while (m_wc < 7 && k < 50) begin
            step();
            k++;
        end
        chk("partial_timeout", 16'(m_wc), 16'd7);
        wq.delete();
        rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_ready", 16'(word_ready), 16'd0);
        chk("mid_rst_underrun", 16'(underrun), 16'd0);
        chk("mid_rst_x_out", x_out, 16'd0);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        check_coefs();
        step();
        rst = 1'b1;
        step();
        chk("rel2_ready", 16'(word_ready), 16'd1);

        en = 1'b1;
        push_frame(16'h0000, 16'h2000, 16'h1357, 16'h2468, 16'h0FED);
        drain();
        step();
        model_load();
        m_phase = 0;
        chk("reload_fs", 16'(frame_start), 16'd1);
        chk("reload_A0", 16'(A0), 16'h1357);
        check_coefs();
        step();
        run_frame(-1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/lpc_frame_sequencer.md
Name: lpc_frame_sequencer

Overview:
- Frame-level controller for the LPC synthesis datapath.
- Accepts per-frame parameters (voiced flag, pitch, gain, A0..A10) as a serial word stream into a shadow buffer.
- Swaps the shadow buffer into the active set at frame boundaries and generates the excitation sample: a gain-scaled pitch pulse when voiced, gain-scaled noise when unvoiced.
- Drives the synthfilt coefficient inputs, x and v; sits between the frame-parameter source and synthfilt, with LFSR output feeding noise_in.

Parameters:
- FRAME_LEN, 240: samples per frame; legal range 2..65535.
- CNT_W, 16: width of the sample counter; must hold FRAME_LEN-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- en  in  1  run enable, sampled at frame boundaries
- sample_tick  in  1  one-cycle sample strobe; consecutive ticks at least 3 clk apart
- word_in  in  16  frame parameter word
- word_valid  in  1  word_in valid
- word_ready  out  1  shadow buffer can accept a word
- noise_in  in  16  signed noise sample (LFSR d_out)
- A0..A10  out  16 each  signed active coefficients to synthfilt
- x_out  out  16  signed excitation sample
- v_out  out  1  one-cycle strobe, x_out valid
- frame_start  out  1  one-cycle pulse on every active-set load
- underrun  out  1  sticky; a frame boundary passed with no complete shadow frame
- busy  out  1  state is RUN

Behaviour:
- Reset (rst=0, async): state IDLE. All of the following are 0: A0..A10, x_out, v_out, frame_start, underrun, busy, word counter, sample counter, pitch counter and shadow_full. word_ready=1 after release.
- Frame word order, 13 words:
  - w0: bit15 = voiced, bits14:0 = pitch in samples.
  - w1: bits14:0 = gain, unsigned Q0.15; bit15 is ignored.
  - w2..w12: A0..A10.
- Shadow fill:
  - word_ready = !shadow_full.
  - A word is accepted on a clk edge with word_valid & word_ready, written to slot word_cnt, and word_cnt increments.
  - Acceptance of w12 sets shadow_full and clears word_cnt.
  - Words are never dropped or overwritten while shadow_full=1.
- Load operation, one cycle:
  - active set <= shadow.
  - shadow_full <= 0.
  - frame_start = 1 for that cycle.
  - sample_cnt <= 0.
  - A0..A10 update on this edge.
- IDLE: when en & shadow_full, perform a load, clear pitch_cnt, and go to RUN. v_out stays 0 in IDLE.
- RUN, on sample_tick:
  - Next edge: v_out=1 for 1 cycle and x_out registers the excitation (latency 1 clk).
  - Voiced and pitch!=0: x_out = gain when pitch_cnt==0, else 0. pitch_cnt increments and wraps to 0 when pitch_cnt >= pitch-1.
  - Unvoiced, or pitch==0: x_out = (noise_in * gain) >>> 15, a signed 16x16 multiply with gain zero-extended. The result always fits in 16 bits; no saturation.
  - pitch_cnt is not cleared across RUN-to-RUN frame changes. If it is >= the new pitch, it wraps on the next tick.
  - sample_cnt increments per tick. The tick with sample_cnt==FRAME_LEN-1 sets frame_end.
- frame_end is handled on the clk after v_out for the last sample, so coefficients never change in the same cycle as v_out:
  - en=0: go to IDLE; the active set holds.
  - en=1 and shadow_full: perform a load and stay in RUN.
  - en=1 and !shadow_full: set underrun=1, sample_cnt <= 0, frame_start pulses, and the previous active set repeats.
- sample_tick while in IDLE is ignored.
- en is ignored mid-frame.
- Reset mid-frame: everything returns to reset values, including partial shadow contents (word_cnt=0).

Optional Feature:
- Macro MUTE_ON_UNDERRUN_EN.
- Defined: an underrun frame forces x_out=0 on every v_out of that frame. v_out still strobes and coefficients repeat. The mute clears at the next successful load.
- Undefined: an underrun frame reuses the previous voiced/pitch/gain and excitation continues unchanged.
- underrun is set in both cases.

Test Plan:
- Reset/idle: hold rst=0 with word_valid=1 -> all outputs 0 and word_ready=0. After release, word_ready=1 and v_out stays 0 with en=0 even with ticks.
- Voiced frame: load w0=0x8004, gain=0x4000, A0=8192, A1=-13493 ... A10=-239; en=1; tick every 4 clk for 240 ticks:
  - frame_start 1 cycle after shadow_full; A0=8192, A10=-239.
  - 240 v_out pulses, each 1 clk after its tick; x_out=16384 on samples 0,4,8,... and 0 otherwise.
- Unvoiced frame: w0=0x0000, gain=0x7FFF, noise_in=-32768 -> x_out=-32767; noise_in=16384 -> x_out=16383.
- Back-to-back frames: second frame loaded mid-frame:
  - word_ready=0 after 13 words.
  - Coefficients change exactly 1 clk after the 240th v_out; frame_start pulses once; underrun stays 0.
- Underrun: no second frame supplied, en=1 -> underrun=1 after sample 240 and coefficients unchanged.
  - With MUTE_ON_UNDERRUN_EN: x_out=0 for all 240 samples of the next frame.
  - Without it: the pulse pattern continues.
- Reset mid-load: assert rst after 7 of 13 words -> word_cnt=0; a fresh 13-word frame then loads correctly with A0 = the new w2.
